// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        GCD_IDLE = 2'd0,
        GCD_CALC = 2'd1,
        GCD_DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_step.sv
// One subtractive Euclid step: either a terminal result or the reduced operand pair.
module gcd_step #(
    parameter int unsigned BusSize = 8
) (
    input  logic [BusSize-1:0] a_i,
    input  logic [BusSize-1:0] b_i,
    output logic [BusSize-1:0] next_a_o,
    output logic [BusSize-1:0] next_b_o,
    output logic               term_o,
    output logic [BusSize-1:0] term_val_o
);

    // Priority: zero operands first, then equality, then subtract the smaller from the larger.
    always_comb begin
        next_a_o   = a_i;
        next_b_o   = b_i;
        term_o     = 1'b0;
        term_val_o = '0;
        if (a_i == '0) begin
            term_o     = 1'b1;
            term_val_o = b_i;
        end else if (b_i == '0) begin
            term_o     = 1'b1;
            term_val_o = a_i;
        end else if (a_i == b_i) begin
            term_o     = 1'b1;
            term_val_o = a_i;
        end else if (a_i > b_i) begin
            next_a_o = a_i - b_i;
        end else begin
            next_b_o = b_i - a_i;
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// Multi-cycle subtractive GCD engine with valid/ready handshakes on both sides.
// Optional iteration counter output enabled by defining GCD_CYCLE_CNT_EN.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int unsigned BusSize = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [BusSize-1:0] A_i,
    input  logic [BusSize-1:0] B_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
`ifdef GCD_CYCLE_CNT_EN
    output logic [BusSize-1:0] cycles_o,
`endif
    output logic [BusSize-1:0] result_o
);

    gcd_state_t         state_q, state_d;
    logic [BusSize-1:0] a_q, a_d;
    logic [BusSize-1:0] b_q, b_d;
    logic [BusSize-1:0] result_q, result_d;

    logic [BusSize-1:0] step_a, step_b, step_val;
    logic               step_term;

    gcd_step #(
        .BusSize(BusSize)
    ) u_step (
        .a_i       (a_q),
        .b_i       (b_q),
        .next_a_o  (step_a),
        .next_b_o  (step_b),
        .term_o    (step_term),
        .term_val_o(step_val)
    );

`ifdef GCD_CYCLE_CNT_EN
    logic [BusSize-1:0] cnt_q, cnt_d;
    logic [BusSize-1:0] cycles_q, cycles_d;

    // Step counter: cleared on accept, saturating count of subtraction steps, latched at finish.
    always_comb begin
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        if (state_q == GCD_IDLE && in_valid_i) begin
            cnt_d = '0;
        end else if (state_q == GCD_CALC) begin
            if (step_term) begin
                cycles_d = cnt_q;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
        end
    end

    assign cycles_o = cycles_q;
`endif

    // Next-state and datapath control; handshake outputs depend only on the state register.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state_q)
            GCD_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    a_d     = A_i;
                    b_d     = B_i;
                    state_d = GCD_CALC;
                end
            end
            GCD_CALC: begin
                if (step_term) begin
                    result_d = step_val;
                    state_d  = GCD_DONE;
                end else begin
                    a_d = step_a;
                    b_d = step_b;
                end
            end
            GCD_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = GCD_IDLE;
                end
            end
            default: begin
                state_d = GCD_IDLE;
            end
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= GCD_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: driver pushes expected results, monitor pops on handshake.
module tb_gcd_engine;

    localparam int unsigned BusSize = 8;
    localparam int unsigned MaxWait = 600;

    typedef struct packed {
        logic [BusSize-1:0] res;
        logic [BusSize-1:0] cyc;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [BusSize-1:0] a_in;
    logic [BusSize-1:0] b_in;
    logic               out_valid;
    logic               out_ready;
    logic [BusSize-1:0] result;
`ifdef GCD_CYCLE_CNT_EN
    logic [BusSize-1:0] cycles;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    int   bp_mode  = 0;  // 0: always ready, 1: stalled, 2: random

    gcd_engine #(
        .BusSize(BusSize)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .A_i        (a_in),
        .B_i        (b_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
`ifdef GCD_CYCLE_CNT_EN
        .cycles_o   (cycles),
`endif
        .result_o   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: gcd via remainder Euclid.
    function automatic int ref_gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Reference: subtraction steps = sum of Euclid quotients minus the final equal-operand step.
    function automatic int ref_steps(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        int s = 0;
        if (a == 0 || b == 0) return 0;
        while (y != 0) begin
            s += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        s = s - 1;
        if (s > (1 << BusSize) - 1) s = (1 << BusSize) - 1;
        return s;
    endfunction

    // Consumer ready pattern, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops expectations on output handshakes, checks hold and return to idle.
    logic               hs_prev   = 1'b0;
    logic               hold_prev = 1'b0;
    logic [BusSize-1:0] hold_res  = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hs_prev   = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                check("idle_after_handshake_valid", int'(out_valid), 0);
                check("idle_after_handshake_ready", int'(in_ready), 1);
            end
            if (out_valid && hold_prev) check("result_held", int'(result), int'(hold_res));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", int'(result), int'(e.res));
`ifdef GCD_CYCLE_CNT_EN
                    check("cycles", int'(cycles), int'(e.cyc));
`endif
                end
            end
            hs_prev   = out_valid && out_ready;
            hold_prev = out_valid && !out_ready;
            hold_res  = result;
        end
    end

    // Present one operand pair and wait for it to be accepted.
    task automatic send(input int a, input int b, input bit push);
        int   k = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && k < MaxWait) begin
            @(negedge clk);
            k++;
        end
        if (k >= MaxWait) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        a_in     = BusSize'(a);
        b_in     = BusSize'(b);
        if (push) begin
            e.res = BusSize'(ref_gcd(a, b));
            e.cyc = BusSize'(ref_steps(a, b));
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid rises.
    task automatic measure(input string name, input int exp_lat);
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!out_valid && k < MaxWait);
        check(name, k, exp_lat);
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 20 * MaxWait) begin
            @(posedge clk);
            k++;
        end
        check("drain_queue_empty", sb_q.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_result", int'(result), 0);
`ifdef GCD_CYCLE_CNT_EN
        check("reset_cycles", int'(cycles), 0);
`endif
        rst = 1'b0;

        // Basic case and latency.
        send(12, 8, 1);
        measure("latency_12_8", 3);
        drain();

        // Zero operands.
        send(0, 9, 1);
        measure("latency_0_9", 1);
        drain();
        send(0, 0, 1);
        send(7, 0, 1);
        drain();

        // Worst-case iteration count.
        send(255, 1, 1);
        measure("latency_255_1", 255);
        drain();

        // Back-pressure hold.
        bp_mode = 1;
        @(posedge clk);
        #2;
        send(21, 14, 1);
        measure("latency_21_14", 3);
        repeat (5) begin
            @(negedge clk);
            check("bp_result", int'(result), 7);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
        end
        bp_mode = 0;
        drain();

        // Reset mid-calculation abandons the operation.
        send(200, 3, 0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_result", int'(result), 0);
`ifdef GCD_CYCLE_CNT_EN
        check("abort_cycles", int'(cycles), 0);
`endif
        rst = 1'b0;
        send(9, 6, 1);
        drain();

        // Input held valid during CALC must be ignored.
        send(30, 18, 1);
        in_valid = 1'b1;
        a_in     = 8'd99;
        b_in     = 8'd77;
        repeat (2) begin
            @(negedge clk);
            check("busy_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        send(17, 5, 1);
        drain();

        // Randomised pairs under random back-pressure.
        bp_mode = 2;
        for (int i = 0; i < 40; i++) begin
            int ra = int'($urandom_range(0, 255));
            int rb = int'($urandom_range(0, 255));
            if (i % 10 == 3) ra = 0;
            if (i % 10 == 7) rb = 0;
            send(ra, rb, 1);
        end
        drain();
        bp_mode = 0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
